// File: rtl/spi_slave_regs.sv
// spi_slave_regs
//   SPI responder (mode 0) that gives an external SPI host access to a byte
//   register file. The local CPU reaches the same registers through a simple
//   bus port. SCK, CSN and MOSI are oversampled in the clk domain.
//
//   Frame: command byte {rw, ms, -, addr}, then N data bytes, MSB first.
//   rw=1 reads. ms enables auto-increment only when SPI_SLAVE_AUTOINC_EN is
//   defined. Otherwise every byte of a frame targets the same register.
//
// Parameters
//   ADDR_W       register address width, 2**ADDR_W byte registers (1..6)
//   SYNC_STAGES  synchronizer depth on SCK/CSN/MOSI (>= 2)
//
// Ports
//   clk, reset     system clock; synchronous active-high reset
//   spi_sck/csn    async SPI clock and active-low chip select
//   spi_mosi       serial data from the host
//   spi_miso       serial data to the host (0 when not selected)
//   spi_miso_oe    MISO output enable (equals spi_busy)
//   bus_addr/wdata local register address and write data
//   bus_we         local one-cycle write strobe
//   bus_rdata      regs[bus_addr], registered, 1-cycle latency
//   spi_wr         one-cycle pulse when an SPI write lands in a register
//   spi_wr_addr    address of that write, valid while spi_wr=1
//   spi_busy       synchronized CSN is low
module spi_slave_regs #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sck,
    input  logic              spi_csn,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [7:0]        bus_wdata,
    input  logic              bus_we,
    output logic [7:0]        bus_rdata,
    output logic              spi_wr,
    output logic [ADDR_W-1:0] spi_wr_addr,
    output logic              spi_busy
);

    localparam int unsigned NREGS = 1 << ADDR_W;

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WRITE, ST_READ} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync, sync_vld;
    logic sck_s, csn_s, mosi_s;
    logic sck_prev, csn_prev, armed;
    logic sck_rise, sck_fall, csn_rise, csn_fall;

    logic [7:0]        regs [NREGS];
    logic [2:0]        bit_cnt;
    logic [7:0]        rx, tx, rx_byte;
    logic              miso_q;
    logic [ADDR_W-1:0] addr, base_addr, adv_addr;
    logic              in_frame, byte_done, spi_commit, inc_now;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        pend_data;

    // Synchronizers and edge detectors. A frame may only start once CSN has
    // been seen high through a fully refilled synchronizer; this keeps the
    // tail of a frame interrupted by reset from looking like a new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '0;
            csn_sync  <= '1;
            mosi_sync <= '0;
            sync_vld  <= '0;
            sck_prev  <= 1'b0;
            csn_prev  <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
            sck_prev  <= sck_s;
            csn_prev  <= csn_s;
            if (sync_vld[SYNC_STAGES-1] && csn_s)
                armed <= 1'b1;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign csn_rise = csn_s & ~csn_prev;
    assign csn_fall = ~csn_s & csn_prev;

    assign in_frame   = (state != ST_IDLE) && !csn_rise;
    assign rx_byte    = {rx[6:0], mosi_s};
    assign byte_done  = in_frame && sck_rise && (bit_cnt == 3'd7);
    assign spi_commit = byte_done && (state == ST_WRITE);

`ifdef SPI_SLAVE_AUTOINC_EN
    logic autoinc;

    always_ff @(posedge clk) begin
        if (reset)
            autoinc <= 1'b0;
        else if (byte_done && state == ST_CMD)
            autoinc <= rx_byte[6];
    end

    // At the command boundary the ms bit is still in the shifter.
    assign inc_now = (state == ST_CMD) ? rx_byte[6] : autoinc;
`else
    assign inc_now = 1'b0;
`endif

    assign base_addr = (state == ST_CMD) ? rx_byte[ADDR_W-1:0] : addr;
    assign adv_addr  = inc_now ? base_addr + ADDR_W'(1) : base_addr;

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (csn_fall && armed) state_next = ST_CMD;
            ST_CMD: begin
                if (csn_rise)
                    state_next = ST_IDLE;
                else if (byte_done)
                    state_next = rx_byte[7] ? ST_READ : ST_WRITE;
            end
            default: if (csn_rise) state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            miso_q      <= 1'b0;
            addr        <= '0;
            pend_valid  <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
            spi_wr      <= 1'b0;
            spi_wr_addr <= '0;
            bus_rdata   <= '0;
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            spi_wr    <= 1'b0;
            bus_rdata <= regs[bus_addr];

            if (!in_frame) begin
                bit_cnt <= '0;
                miso_q  <= 1'b0;
            end else begin
                if (sck_rise) begin
                    rx      <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    if (state == ST_READ || (state == ST_CMD && rx_byte[7]))
                        tx <= regs[base_addr];
                    // A write command only latches its address; the first
                    // data byte commits there before any advance.
                    if (state == ST_CMD && !rx_byte[7])
                        addr <= base_addr;
                    else
                        addr <= adv_addr;
                end
                if (sck_fall && state == ST_READ) begin
                    miso_q <= tx[7];
                    tx     <= {tx[6:0], 1'b0};
                end
            end

            // Bus write first, so a pending SPI write in the same cycle wins.
            if (bus_we)
                regs[bus_addr] <= bus_wdata;

            if (pend_valid) begin
                regs[pend_addr] <= pend_data;
                spi_wr          <= 1'b1;
                spi_wr_addr     <= pend_addr;
                pend_valid      <= 1'b0;
            end

            if (spi_commit) begin
                if (bus_we) begin
                    pend_valid <= 1'b1;
                    pend_addr  <= addr;
                    pend_data  <= rx_byte;
                end else begin
                    regs[addr]  <= rx_byte;
                    spi_wr      <= 1'b1;
                    spi_wr_addr <= addr;
                end
            end
        end
    end

    assign spi_busy    = ~csn_s;
    assign spi_miso_oe = spi_busy;
    assign spi_miso    = miso_q & spi_busy;

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs
//   Self-checking bench for spi_slave_regs (ADDR_W=4, SYNC_STAGES=2).
//   A directed vector table, hand-written corner sequences and randomized
//   frames are checked against a register-array reference model.
module tb_spi_slave_regs;

    localparam int HALF = 5;  // SCK half period in clk cycles

`ifdef SPI_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk, reset;
    logic       spi_sck, spi_csn, spi_mosi, spi_miso, spi_miso_oe;
    logic [3:0] bus_addr;
    logic [7:0] bus_wdata, bus_rdata;
    logic       bus_we, spi_wr, spi_busy;
    logic [3:0] spi_wr_addr;

    spi_slave_regs #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .bus_rdata(bus_rdata), .spi_wr(spi_wr), .spi_wr_addr(spi_wr_addr),
        .spi_busy(spi_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mregs [16];
    int         wr_cnt = 0;
    logic [3:0] wr_addr_q [$];

    always @(negedge clk) begin
        if (spi_wr) begin
            wr_cnt++;
            wr_addr_q.push_back(spi_wr_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nb; i++) begin
            spi_mosi = tx[7-i];
            clk_n(HALF);
            spi_sck = 1'b1;
            rx[7-i] = spi_miso;
            clk_n(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input int n, input logic [31:0] wd,
                             output logic [31:0] rd, output logic [7:0] cmd_rx);
        logic [7:0] b;
        rd = '0;
        spi_csn = 1'b0;
        clk_n(HALF);
        spi_bits(cmd, 8, cmd_rx);
        for (int j = 0; j < n; j++) begin
            spi_bits(wd[31-8*j -: 8], 8, b);
            rd[31-8*j -: 8] = b;
        end
        clk_n(HALF);
        spi_csn = 1'b1;
        clk_n(3*HALF);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        clk_n(1);
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        bus_addr = a;
        clk_n(1);
        d = bus_rdata;
    endtask

    // Single-byte write frame; reports at which clk (after the final SCK rise)
    // spi_wr was first seen, optionally hitting the commit cycle with bus_we.
    task automatic spi_write_timed(input logic [3:0] a, input logic [7:0] d, input bit collide,
                                   input logic [7:0] bd, output int k_seen);
        logic [7:0] junk;
        k_seen = 0;
        spi_csn = 1'b0;
        clk_n(HALF);
        spi_bits({4'h0, a}, 8, junk);
        spi_bits(d, 7, junk);
        spi_mosi = d[0];
        clk_n(HALF);
        spi_sck = 1'b1;
        for (int k = 1; k <= HALF; k++) begin
            clk_n(1);
            if (collide && k == 2) begin
                bus_addr = a; bus_wdata = bd; bus_we = 1'b1;
            end else begin
                bus_we = 1'b0;
            end
            if (spi_wr && k_seen == 0) k_seen = k;
        end
        spi_sck = 1'b0;
        clk_n(HALF);
        spi_csn = 1'b1;
        clk_n(3*HALF);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] exp;     // read data, or register value after a write
        int         exp_wr;  // expected spi_wr pulses
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [31:0] rd;
        logic [7:0]  cmd_rx, b, junk;
        int          w0, k;

        vecs[0] = '{8'h03, 8'hA5, 8'hA5, 1};
        vecs[1] = '{8'h83, 8'h00, 8'hA5, 0};
        vecs[2] = '{8'h0E, 8'h11, 8'h11, 1};
        vecs[3] = '{8'h0F, 8'h22, 8'h22, 1};
        vecs[4] = '{8'h00, 8'h33, 8'h33, 1};
        vecs[5] = '{8'hBE, 8'h00, 8'h11, 0};  // unused cmd bits set
        vecs[6] = '{8'h35, 8'h5C, 8'h5C, 1};
        vecs[7] = '{8'h85, 8'h00, 8'h5C, 0};

        for (int i = 0; i < 16; i++) mregs[i] = '0;
        reset = 1'b1; spi_sck = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0;
        bus_addr = '0; bus_wdata = '0; bus_we = 1'b0;
        clk_n(4);
        reset = 1'b0;
        clk_n(1);
        chk("reset_miso", {31'd0, spi_miso}, 0);
        chk("reset_oe", {31'd0, spi_miso_oe}, 0);
        chk("reset_busy", {31'd0, spi_busy}, 0);
        chk("reset_wr", {31'd0, spi_wr}, 0);
        chk("reset_wr_addr", {28'd0, spi_wr_addr}, 0);
        chk("reset_rdata", {24'd0, bus_rdata}, 0);
        clk_n(5);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            wr_addr_q.delete();
            w0 = wr_cnt;
            spi_frame(vecs[i].cmd, 1, {vecs[i].data, 24'h0}, rd, cmd_rx);
            chk($sformatf("vec%0d_cmd_miso", i), {24'd0, cmd_rx}, 0);
            chk($sformatf("vec%0d_wr_cnt", i), wr_cnt - w0, vecs[i].exp_wr);
            if (vecs[i].cmd[7]) begin
                chk($sformatf("vec%0d_rdata", i), {24'd0, rd[31:24]}, {24'd0, vecs[i].exp});
            end else begin
                mregs[vecs[i].cmd[3:0]] = vecs[i].data;
                if (wr_addr_q.size() > 0)
                    chk($sformatf("vec%0d_wr_addr", i), {28'd0, wr_addr_q[0]}, {28'd0, vecs[i].cmd[3:0]});
                bus_read(vecs[i].cmd[3:0], b);
                chk($sformatf("vec%0d_bus_rd", i), {24'd0, b}, {24'd0, vecs[i].exp});
            end
        end

        // Burst read across the address wrap 15 -> 0
        spi_frame(8'hCE, 3, 32'h0, rd, cmd_rx);
        chk("burst_cmd_miso", {24'd0, cmd_rx}, 0);
        chk("burst_rdata", {8'd0, rd[31:8]}, AUTOINC ? 32'h00112233 : 32'h00111111);

        // Normal commit timing, then collision with a bus write
        spi_write_timed(4'd2, 8'h77, 1'b0, 8'h00, k);
        chk("wr_latency", k, 3);
        mregs[2] = 8'h77;
        spi_write_timed(4'd2, 8'h5A, 1'b1, 8'hC3, k);
        chk("coll_latency", k, 4);
        mregs[2] = 8'h5A;
        bus_read(4'd2, b);
        chk("coll_final", {24'd0, b}, 32'h5A);
        chk("coll_wr_addr", {28'd0, spi_wr_addr}, 2);

        // Abort after 5 data bits, then a clean frame
        w0 = wr_cnt;
        spi_csn = 1'b0;
        clk_n(HALF);
        chk("abort_busy", {31'd0, spi_busy}, 1);
        chk("abort_oe", {31'd0, spi_miso_oe}, 1);
        spi_bits(8'h04, 8, junk);
        spi_bits(8'hFF, 5, junk);
        clk_n(HALF);
        spi_csn = 1'b1;
        clk_n(3*HALF);
        chk("abort_no_wr", wr_cnt - w0, 0);
        bus_read(4'd4, b);
        chk("abort_reg", {24'd0, b}, {24'd0, mregs[4]});
        spi_frame(8'h04, 1, 32'h7E000000, rd, cmd_rx);
        mregs[4] = 8'h7E;
        bus_read(4'd4, b);
        chk("restart_reg", {24'd0, b}, 32'h7E);

        // SCK activity with CSN high
        w0 = wr_cnt;
        for (int i = 0; i < 16; i++) begin
            spi_mosi = 1'($urandom);
            clk_n(HALF); spi_sck = 1'b1;
            clk_n(HALF); spi_sck = 1'b0;
            chk("idle_oe", {31'd0, spi_miso_oe}, 0);
            chk("idle_miso", {31'd0, spi_miso}, 0);
        end
        chk("idle_no_wr", wr_cnt - w0, 0);
        spi_frame(8'h83, 1, 32'h0, rd, cmd_rx);
        chk("idle_then_read", {24'd0, rd[31:24]}, {24'd0, mregs[3]});

        // Reset after 12 SCK rises of a write frame
        w0 = wr_cnt;
        spi_csn = 1'b0;
        clk_n(HALF);
        spi_bits(8'h05, 8, junk);
        spi_bits(8'hE7, 4, junk);
        reset = 1'b1;
        clk_n(2);
        chk("rst_mid_oe", {31'd0, spi_miso_oe}, 0);
        chk("rst_mid_busy", {31'd0, spi_busy}, 0);
        chk("rst_mid_miso", {31'd0, spi_miso}, 0);
        chk("rst_mid_wr", {31'd0, spi_wr}, 0);
        chk("rst_mid_wr_addr", {28'd0, spi_wr_addr}, 0);
        chk("rst_mid_rdata", {24'd0, bus_rdata}, 0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        spi_bits(8'h70, 4, junk);
        clk_n(HALF);
        spi_csn = 1'b1;
        clk_n(3*HALF);
        chk("rst_no_wr", wr_cnt - w0, 0);
        bus_read(4'd5, b);
        chk("rst_reg5", {24'd0, b}, 0);
        spi_frame(8'h05, 1, 32'h99000000, rd, cmd_rx);
        mregs[5] = 8'h99;
        bus_read(4'd5, b);
        chk("rst_fresh", {24'd0, b}, 32'h99);
        chk("rst_fresh_wr", wr_cnt - w0, 1);

        // Randomized frames against the register-array model
        for (int f = 0; f < 40; f++) begin
            logic        rw, ms;
            logic [3:0]  a, idx;
            logic [1:0]  junk_bits;
            logic [31:0] wd;
            int          n;
            rw = 1'($urandom); ms = 1'($urandom); junk_bits = 2'($urandom);
            a = 4'($urandom_range(0, 15));
            n = $urandom_range(1, 4);
            wd = $urandom();
            if ($urandom_range(0, 1) == 1) begin
                idx = 4'($urandom_range(0, 15));
                b = 8'($urandom);
                bus_write(idx, b);
                mregs[idx] = b;
            end
            wr_addr_q.delete();
            spi_frame({rw, ms, junk_bits, a}, n, wd, rd, cmd_rx);
            chk("rnd_cmd_miso", {24'd0, cmd_rx}, 0);
            chk("rnd_wr_cnt", wr_addr_q.size(), rw ? 0 : n);
            for (int j = 0; j < n; j++) begin
                idx = 4'((int'(a) + ((AUTOINC && ms) ? j : 0)) % 16);
                if (rw) begin
                    chk("rnd_rdata", {24'd0, rd[31-8*j -: 8]}, {24'd0, mregs[idx]});
                end else begin
                    mregs[idx] = wd[31-8*j -: 8];
                    if (j < wr_addr_q.size())
                        chk("rnd_wr_addr", {28'd0, wr_addr_q[j]}, {28'd0, idx});
                end
            end
            idx = 4'($urandom_range(0, 15));
            bus_read(idx, b);
            chk("rnd_bus_rd", {24'd0, b}, {24'd0, mregs[idx]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
